data_line_memory: RTL

DATA_LINE_MEMORY -- requirements
Module: data_line_memory

---
 rtl/data_line_memory.sv | 129 ++++++++++++
 1 files changed

// File: rtl/data_line_memory.sv
// Line-oriented backing store for a data cache: fixed-latency line fills and
// write-backs, with a one-cycle done pulse at the end of each access.
module data_line_memory #(
  parameter int c_block_size   = 2,
  parameter int c_line_size    = 32,
  parameter int address_size   = 32,
  parameter int mem_line_size  = 32,
  parameter int mem_lines_log2 = 8,
  parameter int access_cycles  = 5
) (
  input  logic                                        clock,
  input  logic                                        reset,
  input  logic                                        read,
  input  logic                                        write,
  input  logic [address_size-c_block_size-3:0]        address,
  input  logic [(2**c_block_size)*c_line_size-1:0]    writedata,
  output logic                                        busywait,
  output logic [(2**c_block_size)*c_line_size-1:0]    readdata,
  output logic                                        write_done,
  output logic                                        read_done
);

  localparam int words  = 2**c_block_size;
  localparam int line_w = words * c_line_size;
  localparam int addr_w = address_size - c_block_size - 2;
  localparam int depth  = 2**(mem_lines_log2 + c_block_size);

  typedef enum logic [1:0] {IDLE, READ_BUSY, WRITE_BUSY, DONE} state_t;

  state_t                    state, state_next;
  logic [3:0]                count;
  logic [mem_lines_log2-1:0] line_idx;
  logic [line_w-1:0]         line_buf;
  logic                      op_write;
  logic [line_w-1:0]         stored_line;
  logic                      access_end;
  logic [mem_line_size-1:0]  storage [depth];

  // Only the low address bits select a line; the rest alias.
  logic unused_addr;
  assign unused_addr = ^address[addr_w-1:mem_lines_log2];

  assign access_end = (count == 4'd0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: defaults at the top of every combinational block keep each output
  // assigned on all paths, so no latches are inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (write)     state_next = WRITE_BUSY;
        else if (read) state_next = READ_BUSY;
      end
      READ_BUSY:  if (access_end) state_next = DONE;
      WRITE_BUSY: if (access_end) state_next = DONE;
      DONE:       state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  always_comb begin
    busywait   = 1'b0;
    read_done  = 1'b0;
    write_done = 1'b0;
    case (state)
      IDLE:       busywait = read | write;
      READ_BUSY:  busywait = 1'b1;
      WRITE_BUSY: busywait = 1'b1;
      DONE: begin
        read_done  = ~op_write;
        write_done = op_write;
      end
      default: ;
    endcase
  end

  // Request latches, access counter and the returned line.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count    <= '0;
      line_idx <= '0;
      line_buf <= '0;
      op_write <= 1'b0;
      readdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (write || read) begin
            count    <= 4'(access_cycles - 1);
            line_idx <= address[mem_lines_log2-1:0];
            op_write <= write;
          end
          if (write) line_buf <= writedata;
        end
        READ_BUSY: begin
          if (!access_end) count <= count - 4'd1;
          else             readdata <= stored_line;
        end
        WRITE_BUSY: if (!access_end) count <= count - 4'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    stored_line = '0;
    for (int i = 0; i < words; i++)
      stored_line[i*c_line_size +: c_line_size] =
        c_line_size'(storage[{line_idx, c_block_size'(i)}]);
  end

  // NOTE: the storage array has no reset; clearing it would need a port per
  // word, and its contents must survive a reset anyway.
  always_ff @(posedge clock) begin
    if (state == WRITE_BUSY && access_end) begin
      for (int i = 0; i < words; i++)
        storage[{line_idx, c_block_size'(i)}] <=
          mem_line_size'(line_buf[i*c_line_size +: c_line_size]);
    end
  end

endmodule
